frogger_game_ctrl: RTL and testbench

Game sequencer for the frogger display path. It owns frog position, per-lane car offsets, lives and score, and runs the game state machine. All updates happen once per video frame. The renderer (fed by hvsync_generator counters) reads its outputs and returns a frog/car overlap flag.

---
 rtl/frogger_pkg.sv | 24 ++
 rtl/frogger_game_ctrl_if.sv | 33 +++
 rtl/frogger_lane_mover.sv | 42 ++++
 rtl/frogger_game_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/frogger_pkg.sv
// Shared constants and types for the frogger game sequencer.
// Screen geometry, lane offset width, game-state and pending-move encodings.
package frogger_pkg;

  localparam int SCREEN_H_ACTIVE = 640;
  localparam int SCREEN_V_ACTIVE = 480;
  localparam int OFS_W           = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2,
    OVER = 2'd3
  } game_state_t;

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_UP    = 3'd1,
    MV_DOWN  = 3'd2,
    MV_LEFT  = 3'd3,
    MV_RIGHT = 3'd4
  } move_t;

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// Renderer <-> game sequencer bundle; master is the renderer/input side, slave the sequencer.
// Frame-paced, no backpressure; time_left exists only when FROGGER_TIMER_EN is defined.
interface frogger_game_ctrl_if #(
  parameter int NUM_LANES = 5
) ();
  import frogger_pkg::*;

  logic                       frame_start;
  logic                       btn_up;
  logic                       btn_down;
  logic                       btn_left;
  logic                       btn_right;
  logic                       collide;
  logic [9:0]                 frog_x;
  logic [8:0]                 frog_y;
  logic [OFS_W*NUM_LANES-1:0] lane_offset;
  logic [1:0]                 lives;
  logic [7:0]                 score;
  logic [1:0]                 game_state;
`ifdef FROGGER_TIMER_EN
  logic [9:0]                 time_left;

  modport master (output frame_start, btn_up, btn_down, btn_left, btn_right, collide,
                  input  frog_x, frog_y, lane_offset, lives, score, game_state, time_left);
  modport slave  (input  frame_start, btn_up, btn_down, btn_left, btn_right, collide,
                  output frog_x, frog_y, lane_offset, lives, score, game_state, time_left);
`else
  modport master (output frame_start, btn_up, btn_down, btn_left, btn_right, collide,
                  input  frog_x, frog_y, lane_offset, lives, score, game_state);
  modport slave  (input  frame_start, btn_up, btn_down, btn_left, btn_right, collide,
                  output frog_x, frog_y, lane_offset, lives, score, game_state);
`endif
endinterface

// File: rtl/frogger_lane_mover.sv
// One car lane: frame divider plus wrapping offset; steps once every DIV enabled frames.
// Latency: offset visible the cycle after the step_en pulse; no backpressure.
module frogger_lane_mover
  import frogger_pkg::*;
#(
  parameter int DIV      = 1,
  parameter bit DEC      = 1'b0,
  parameter int H_ACTIVE = SCREEN_H_ACTIVE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  output logic [OFS_W-1:0] offset
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(H_ACTIVE - 1);

  logic [CW-1:0]    div_cnt;
  logic [OFS_W-1:0] offset_nxt;

  always_comb begin
    offset_nxt = offset + 1'b1;
    if (DEC) offset_nxt = (offset == '0) ? LAST_OFS : offset - 1'b1;
    else if (offset == LAST_OFS) offset_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      offset  <= '0;
    end else if (step_en) begin
      if (div_cnt == CW'(DIV - 1)) begin
        div_cnt <= '0;
        offset  <= offset_nxt;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: frog, lanes, lives, score and game FSM, all stepped on frame_start.
// Outputs registered (visible the cycle after the pulse); no backpressure. Option: FROGGER_TIMER_EN.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int NUM_LANES    = 5,
  parameter int H_ACTIVE     = SCREEN_H_ACTIVE,
  parameter int FROG_STEP    = 32,
  parameter int FROG_START_X = 304,
  parameter int FROG_START_Y = 448,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60
`ifdef FROGGER_TIMER_EN
  , parameter int TIMER_FRAMES = 900
`endif
) (
  input  logic                clk,
  input  logic                reset,
  frogger_game_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DEATH_FRAMES + 1);

  game_state_t state_q, state_d;
  move_t       pend_q, pend_d, btn_move;
  logic [9:0]  frog_x_q, frog_x_d, mv_x;
  logic [8:0]  frog_y_q, frog_y_d, mv_y;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic        hit_q, hit_d, tmo;
  logic [DW-1:0] dcnt_q, dcnt_d;
`ifdef FROGGER_TIMER_EN
  logic [9:0]  timer_q, timer_d;
  assign tmo = (timer_q <= 10'd1);
  assign bus.time_left = timer_q;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    btn_move = MV_NONE;
    if (bus.btn_up)         btn_move = MV_UP;
    else if (bus.btn_down)  btn_move = MV_DOWN;
    else if (bus.btn_left)  btn_move = MV_LEFT;
    else if (bus.btn_right) btn_move = MV_RIGHT;
  end

  // Candidate position; moves leaving the playfield are dropped here.
  always_comb begin
    mv_x = frog_x_q;
    mv_y = frog_y_q;
    case (pend_q)
      MV_UP:    if (int'(frog_y_q) >= FROG_STEP) mv_y = frog_y_q - 9'(FROG_STEP);
      MV_DOWN:  if (int'(frog_y_q) + FROG_STEP <= FROG_START_Y) mv_y = frog_y_q + 9'(FROG_STEP);
      MV_LEFT:  if (int'(frog_x_q) >= FROG_STEP) mv_x = frog_x_q - 10'(FROG_STEP);
      MV_RIGHT: if (int'(frog_x_q) + 2 * FROG_STEP <= H_ACTIVE) mv_x = frog_x_q + 10'(FROG_STEP);
      default:  ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    frog_x_d = frog_x_q;
    frog_y_d = frog_y_q;
    lives_d  = lives_q;
    score_d  = score_q;
    hit_d    = hit_q;
    dcnt_d   = dcnt_q;
`ifdef FROGGER_TIMER_EN
    timer_d  = timer_q;
`endif
    if (!bus.frame_start) begin
      // IDLE/OVER also latch presses, only to trigger their transitions.
      if (btn_move != MV_NONE && state_q != DEAD) pend_d = btn_move;
      if (bus.collide && state_q == PLAY) hit_d = 1'b1;
    end else begin
      pend_d = MV_NONE;
      hit_d  = 1'b0;
      case (state_q)
        IDLE: if (pend_q != MV_NONE) begin
          state_d  = PLAY;
          lives_d  = 2'(START_LIVES);
          score_d  = '0;
          frog_x_d = 10'(FROG_START_X);
          frog_y_d = 9'(FROG_START_Y);
`ifdef FROGGER_TIMER_EN
          timer_d  = 10'(TIMER_FRAMES);
`endif
        end
        PLAY: begin
`ifdef FROGGER_TIMER_EN
          timer_d = timer_q - 1'b1;
`endif
          if (hit_q || tmo) begin
            state_d = DEAD;
            lives_d = lives_q - 2'd1;
            dcnt_d  = '0;
          end else if (mv_y == '0) begin
            score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            frog_x_d = 10'(FROG_START_X);
            frog_y_d = 9'(FROG_START_Y);
`ifdef FROGGER_TIMER_EN
            timer_d  = 10'(TIMER_FRAMES);
`endif
          end else begin
            frog_x_d = mv_x;
            frog_y_d = mv_y;
          end
        end
        DEAD: begin
          if (dcnt_q == DW'(DEATH_FRAMES - 1)) begin
            if (lives_q == '0) begin
              state_d = OVER;
            end else begin
              state_d  = PLAY;
              frog_x_d = 10'(FROG_START_X);
              frog_y_d = 9'(FROG_START_Y);
`ifdef FROGGER_TIMER_EN
              timer_d  = 10'(TIMER_FRAMES);
`endif
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        OVER: if (pend_q != MV_NONE) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q   <= MV_NONE;
      frog_x_q <= 10'(FROG_START_X);
      frog_y_q <= 9'(FROG_START_Y);
      lives_q  <= 2'(START_LIVES);
      score_q  <= '0;
      hit_q    <= 1'b0;
      dcnt_q   <= '0;
`ifdef FROGGER_TIMER_EN
      timer_q  <= 10'(TIMER_FRAMES);
`endif
    end else begin
      pend_q   <= pend_d;
      frog_x_q <= frog_x_d;
      frog_y_q <= frog_y_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      dcnt_q   <= dcnt_d;
`ifdef FROGGER_TIMER_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign bus.frog_x     = frog_x_q;
  assign bus.frog_y     = frog_y_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.game_state = state_q;

  logic lane_step;
  assign lane_step = bus.frame_start && (state_q != OVER);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    frogger_lane_mover #(
      .DIV      (i + 1),
      .DEC      (1'(i % 2)),
      .H_ACTIVE (H_ACTIVE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .step_en (lane_step),
      .offset  (bus.lane_offset[OFS_W*i +: OFS_W])
    );
  end

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Bench for frogger_game_ctrl: directed scenarios plus randomized frames against a rule-level model.
module tb_frogger_game_ctrl;
  import frogger_pkg::*;

  localparam int NL = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frogger_game_ctrl_if #(.NUM_LANES(NL)) bus ();
  frogger_game_ctrl #(.NUM_LANES(NL)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int fails  = 0;

  // Reference model: 0 IDLE 1 PLAY 2 DEAD 3 OVER; pend 0 none 1 up 2 down 3 left 4 right
  int m_state, m_x, m_y, m_lives, m_score, m_pend, m_hit, m_dcnt, m_n;

  // Lane position follows directly from the count of non-OVER frames.
  function automatic int exp_lane(input int i, input int n);
    int s;
    s = (n / (i + 1)) % 640;
    return (i % 2 == 0) ? s : (640 - s) % 640;
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 304; m_y = 448; m_lives = 3; m_score = 0;
    m_pend = 0; m_hit = 0; m_dcnt = 0; m_n = 0;
  endtask

  task automatic model_frame();
    int nx, ny;
    if (m_state != 3) m_n++;
    case (m_state)
      0: if (m_pend != 0) begin
        m_state = 1; m_lives = 3; m_score = 0; m_x = 304; m_y = 448;
      end
      1: if (m_hit != 0) begin
        m_state = 2; m_lives--; m_dcnt = 0;
      end else begin
        nx = m_x; ny = m_y;
        if (m_pend == 1 && m_y >= 32) ny = m_y - 32;
        if (m_pend == 2 && m_y + 32 <= 448) ny = m_y + 32;
        if (m_pend == 3 && m_x >= 32) nx = m_x - 32;
        if (m_pend == 4 && m_x + 64 <= 640) nx = m_x + 32;
        if (ny == 0) begin
          m_score = (m_score < 255) ? m_score + 1 : 255; m_x = 304; m_y = 448;
        end else begin
          m_x = nx; m_y = ny;
        end
      end
      2: if (m_dcnt == 59) begin
        if (m_lives == 0) m_state = 3;
        else begin m_state = 1; m_x = 304; m_y = 448; end
      end else m_dcnt++;
      default: if (m_pend != 0) m_state = 0;
    endcase
    m_pend = 0; m_hit = 0;
  endtask

  task automatic press(input int b);
    @(negedge clk);
    bus.btn_up = (b == 1); bus.btn_down = (b == 2);
    bus.btn_left = (b == 3); bus.btn_right = (b == 4);
    if (m_state != 2) m_pend = b;
    @(negedge clk);
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
  endtask

  task automatic hit();
    @(negedge clk);
    bus.collide = 1;
    if (m_state == 1) m_hit = 1;
    @(negedge clk);
    bus.collide = 0;
  endtask

  task automatic frame();
    @(negedge clk);
    bus.frame_start = 1;
    @(negedge clk);
    bus.frame_start = 0;
    model_frame();
  endtask

  task automatic test_reset();
    bus.frame_start = 0; bus.collide = 0;
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    reset = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.game_state !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", bus.game_state); end
    checks++; if (bus.frog_x !== 10'd304) begin fails++; $display("FAIL reset_x got=%0d exp=304", bus.frog_x); end
    checks++; if (bus.frog_y !== 9'd448) begin fails++; $display("FAIL reset_y got=%0d exp=448", bus.frog_y); end
    checks++; if (bus.lives !== 2'd3) begin fails++; $display("FAIL reset_lives got=%0d exp=3", bus.lives); end
    checks++; if (bus.score !== 8'd0) begin fails++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
    checks++; if (bus.lane_offset !== '0) begin fails++; $display("FAIL reset_lanes got=%h exp=0", bus.lane_offset); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_idle_lanes();
    for (int f = 1; f <= 3; f++) begin
      frame();
      checks++; if (bus.game_state !== 2'd0) begin fails++; $display("FAIL idle_state f=%0d got=%0d exp=0", f, bus.game_state); end
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (int'(bus.lane_offset[10*i +: 10]) != exp_lane(i, m_n)) begin
          fails++; $display("FAIL idle_lane f=%0d lane=%0d got=%0d exp=%0d", f, i, bus.lane_offset[10*i +: 10], exp_lane(i, m_n));
        end
      end
    end
    checks++; if (bus.lane_offset[9:0] !== 10'd3) begin fails++; $display("FAIL idle_lane0 got=%0d exp=3", bus.lane_offset[9:0]); end
    checks++; if (bus.lane_offset[19:10] !== 10'd639) begin fails++; $display("FAIL idle_lane1 got=%0d exp=639", bus.lane_offset[19:10]); end
  endtask

  task automatic test_cross();
    press(1); frame();
    checks++; if (bus.game_state !== 2'd1) begin fails++; $display("FAIL start_state got=%0d exp=1", bus.game_state); end
    for (int k = 0; k < 15; k++) begin
      press(1); frame();
      checks++; if (int'(bus.frog_y) != m_y) begin fails++; $display("FAIL cross_y k=%0d got=%0d exp=%0d", k, bus.frog_y, m_y); end
      checks++; if (int'(bus.score) != m_score) begin fails++; $display("FAIL cross_score k=%0d got=%0d exp=%0d", k, bus.score, m_score); end
      if (k == 13) begin
        checks++; if (bus.score !== 8'd1 || bus.frog_y !== 9'd448) begin
          fails++; $display("FAIL cross_win score=%0d y=%0d exp score=1 y=448", bus.score, bus.frog_y);
        end
      end
    end
  endtask

  task automatic test_edges();
    for (int k = 0; k < 11; k++) begin
      press(3); frame();
      checks++; if (int'(bus.frog_x) != m_x) begin fails++; $display("FAIL edge_left k=%0d got=%0d exp=%0d", k, bus.frog_x, m_x); end
    end
    checks++; if (bus.frog_x !== 10'd16) begin fails++; $display("FAIL edge_left_min got=%0d exp=16", bus.frog_x); end
    for (int k = 0; k < 20; k++) begin
      press(4); frame();
      checks++; if (int'(bus.frog_x) != m_x) begin fails++; $display("FAIL edge_right k=%0d got=%0d exp=%0d", k, bus.frog_x, m_x); end
    end
    checks++; if (bus.frog_x !== 10'd592) begin fails++; $display("FAIL edge_right_max got=%0d exp=592", bus.frog_x); end
  endtask

  task automatic wait_death(input string tag);
    for (int f = 0; f < 60; f++) begin
      if (f < 3) press(2);
      frame();
      checks++; if (int'(bus.game_state) != m_state) begin fails++; $display("FAIL %s_dead_state f=%0d got=%0d exp=%0d", tag, f, bus.game_state, m_state); end
    end
  endtask

  task automatic test_death();
    press(1); hit(); frame();
    checks++; if (bus.game_state !== 2'd2 || bus.lives !== 2'd2) begin
      fails++; $display("FAIL death_enter state=%0d lives=%0d exp state=2 lives=2", bus.game_state, bus.lives);
    end
    wait_death("death");
    checks++; if (bus.game_state !== 2'd1 || bus.frog_x !== 10'd304 || bus.frog_y !== 9'd448) begin
      fails++; $display("FAIL death_respawn state=%0d x=%0d y=%0d exp 1,304,448", bus.game_state, bus.frog_x, bus.frog_y);
    end
  endtask

  task automatic test_hit_win();
    int sc;
    repeat (13) begin press(1); frame(); end
    checks++; if (bus.frog_y !== 9'd32) begin fails++; $display("FAIL hitwin_setup got=%0d exp=32", bus.frog_y); end
    sc = m_score;
    press(1); hit(); frame();
    checks++; if (bus.game_state !== 2'd2 || int'(bus.score) != sc) begin
      fails++; $display("FAIL hitwin state=%0d score=%0d exp state=2 score=%0d", bus.game_state, bus.score, sc);
    end
    wait_death("hitwin");
  endtask

  task automatic test_game_over();
    logic [10*NL-1:0] frozen;
    hit(); frame();
    checks++; if (bus.lives !== 2'd0) begin fails++; $display("FAIL over_lives got=%0d exp=0", bus.lives); end
    wait_death("over");
    checks++; if (bus.game_state !== 2'd3) begin fails++; $display("FAIL over_state got=%0d exp=3", bus.game_state); end
    frozen = bus.lane_offset;
    repeat (4) frame();
    checks++; if (bus.lane_offset !== frozen) begin fails++; $display("FAIL over_frozen got=%h exp=%h", bus.lane_offset, frozen); end
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (int'(bus.lane_offset[10*i +: 10]) != exp_lane(i, m_n)) begin
        fails++; $display("FAIL over_lane lane=%0d got=%0d exp=%0d", i, bus.lane_offset[10*i +: 10], exp_lane(i, m_n));
      end
    end
    press(3); frame();
    checks++; if (bus.game_state !== 2'd0) begin fails++; $display("FAIL over_to_idle got=%0d exp=0", bus.game_state); end
  endtask

  task automatic test_random();
    int b;
    press(1);
    @(negedge clk);
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
    checks++; if (bus.game_state !== 2'd0 || bus.lane_offset !== '0) begin
      fails++; $display("FAIL rand_reset state=%0d lanes=%h exp 0", bus.game_state, bus.lane_offset);
    end
    for (int it = 0; it < 500; it++) begin
      repeat ($urandom_range(0, 2)) begin
        b = int'($urandom_range(0, 7));
        press((b <= 3 || b == 7) ? 1 : b - 2);
      end
      if ($urandom_range(0, 11) == 0) hit();
      frame();
      checks++;
      if (int'(bus.game_state) != m_state || int'(bus.frog_x) != m_x || int'(bus.frog_y) != m_y ||
          int'(bus.lives) != m_lives || int'(bus.score) != m_score) begin
        fails++;
        $display("FAIL rand_core it=%0d got st=%0d x=%0d y=%0d l=%0d s=%0d exp st=%0d x=%0d y=%0d l=%0d s=%0d",
                 it, bus.game_state, bus.frog_x, bus.frog_y, bus.lives, bus.score, m_state, m_x, m_y, m_lives, m_score);
      end
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (int'(bus.lane_offset[10*i +: 10]) != exp_lane(i, m_n)) begin
          fails++; $display("FAIL rand_lane it=%0d lane=%0d got=%0d exp=%0d", it, i, bus.lane_offset[10*i +: 10], exp_lane(i, m_n));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_lanes();
    test_cross();
    test_edges();
    test_death();
    test_hit_win();
    test_game_over();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
